cond_logic: RTL and testbench

Conditional-execution and flag unit for the single-cycle ARM datapath. It consumes the control bundle produced by the instruction decoder (PCS, RegW, NoWrite, MemW, FlagW) together with the instruction's Cond field and the ALU flags, and decides which writes actually commit. It holds the architectural NZCV flag register and sequences multi-cycle (MUL/DIV) instructions through a small FSM that stalls the PC.

---
 rtl/cond_pkg.sv | 31 +++
 rtl/cond_logic_if.sv | 33 +++
 rtl/cond_check.sv | 39 +++
 rtl/cond_logic.sv | 107 ++++++++++
 tb/tb_cond_logic.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution unit: ARM condition codes,
// NZCV bit positions and the multi-cycle sequencer state encoding.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU-facing bundle of the conditional-execution unit.
// The master side is the decoder/datapath, the slave side is cond_logic.
interface cond_logic_if;
  import cond_pkg::*;

  logic       PCS;
  logic       RegW;
  logic       NoWrite;
  logic       MemW;
  logic [1:0] FlagW;
  logic       MStart;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       MBusy;

  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       MCycleStart;
  logic       Stall;
  logic [3:0] Flags;

  modport master (
    output PCS, RegW, NoWrite, MemW, FlagW, MStart, Cond, ALUFlags, MBusy,
    input  PCSrc, RegWrite, MemWrite, MCycleStart, Stall, Flags
  );

  modport slave (
    input  PCS, RegW, NoWrite, MemW, FlagW, MStart, Cond, ALUFlags, MBusy,
    output PCSrc, RegWrite, MemWrite, MCycleStart, Stall, Flags
  );

endinterface

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field against NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condEx
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_condEx = 1'b0;
    case (i_cond)
      COND_EQ: o_condEx = w_z;
      COND_NE: o_condEx = ~w_z;
      COND_CS: o_condEx = w_c;
      COND_CC: o_condEx = ~w_c;
      COND_MI: o_condEx = w_n;
      COND_PL: o_condEx = ~w_n;
      COND_VS: o_condEx = w_v;
      COND_VC: o_condEx = ~w_v;
      COND_HI: o_condEx = w_c & ~w_z;
      COND_LS: o_condEx = ~w_c | w_z;
      COND_GE: o_condEx = (w_n == w_v);
      COND_LT: o_condEx = (w_n != w_v);
      COND_GT: o_condEx = ~w_z & (w_n == w_v);
      COND_LE: o_condEx = w_z | (w_n != w_v);
      COND_AL: o_condEx = 1'b1;
      default: o_condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution and flag unit with a MUL/DIV stall sequencer.
// Optional COND_CARRY_OUT_EN adds the o_CarryIn port (registered C flag).
module cond_logic
  import cond_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  cond_logic_if.slave bus
`ifdef COND_CARRY_OUT_EN
  ,
  output logic        o_CarryIn
`endif
);

  logic [1:0] r_state;
  logic [1:0] w_nextState;
  logic [3:0] r_flags;
  logic       w_condEx;
  logic       w_flagEn;
  logic       w_pcSrcBase;
  logic       w_regWriteBase;
  logic       w_memWriteBase;

  cond_check u_check (
    .i_cond   (bus.Cond),
    .i_flags  (r_flags),
    .o_condEx (w_condEx)
  );

  assign w_pcSrcBase    = bus.PCS & w_condEx;
  assign w_regWriteBase = bus.RegW & w_condEx & ~bus.NoWrite;
  assign w_memWriteBase = bus.MemW & w_condEx;

  // While reset is high the unit behaves as plain base gating: no stall, no start.
  always_comb begin
    bus.PCSrc       = w_pcSrcBase;
    bus.RegWrite    = w_regWriteBase;
    bus.MemWrite    = w_memWriteBase;
    bus.MCycleStart = 1'b0;
    bus.Stall       = 1'b0;
    w_flagEn        = 1'b0;
    w_nextState     = r_state;
    if (!i_reset) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.MStart && w_condEx) begin
            bus.MCycleStart = 1'b1;
            bus.Stall       = 1'b1;
            bus.PCSrc       = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.MemWrite    = 1'b0;
            w_nextState     = ST_BUSY;
          end else begin
            w_flagEn = 1'b1;
          end
        end
        ST_BUSY: begin
          bus.Stall    = 1'b1;
          bus.PCSrc    = 1'b0;
          bus.RegWrite = 1'b0;
          bus.MemWrite = 1'b0;
          if (!bus.MBusy) begin
            w_nextState = ST_DONE;
          end
        end
        ST_DONE: begin
          w_flagEn    = 1'b1;
          w_nextState = ST_IDLE;
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // N,Z and C,V are enabled independently; disabled pairs hold their value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags <= 4'b0000;
    end else if (w_flagEn && w_condEx) begin
      if (bus.FlagW[1]) begin
        r_flags[FLAG_N] <= bus.ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (bus.FlagW[0]) begin
        r_flags[FLAG_C] <= bus.ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
    end
  end

  assign bus.Flags = r_flags;

`ifdef COND_CARRY_OUT_EN
  assign o_CarryIn = r_flags[FLAG_C];
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed steps followed by random
// stimulus, all compared against an architectural model of ARM conditions.
module tb_cond_logic;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cond_logic_if bus ();

`ifdef COND_CARRY_OUT_EN
  logic carryIn;
`endif

  cond_logic dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
`ifdef COND_CARRY_OUT_EN
    ,
    .o_CarryIn (carryIn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: NZCV register plus a phase (0 ready, 1 waiting on MBusy, 2 writeback).
  logic [3:0] mFlags;
  int         mPhase;

  // Architectural rule: Cond[3:1] picks a base test, Cond[0] inverts it.
  function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic ePc, input logic eReg, input logic eMem,
                             input logic eStart, input logic eStall);
    checkValue("PCSrc",       {3'b0, bus.PCSrc},       {3'b0, ePc});
    checkValue("RegWrite",    {3'b0, bus.RegWrite},    {3'b0, eReg});
    checkValue("MemWrite",    {3'b0, bus.MemWrite},    {3'b0, eMem});
    checkValue("MCycleStart", {3'b0, bus.MCycleStart}, {3'b0, eStart});
    checkValue("Stall",       {3'b0, bus.Stall},       {3'b0, eStall});
    checkValue("Flags",       bus.Flags,               mFlags);
`ifdef COND_CARRY_OUT_EN
    checkValue("CarryIn",     {3'b0, carryIn},         {3'b0, mFlags[1]});
`endif
  endtask

  // One clock of stimulus: drive, check before the edge, advance the model.
  task automatic applyStimulus(input logic rst, input logic [3:0] cond,
                               input logic pcs, input logic regw, input logic nowrite,
                               input logic memw, input logic [1:0] flagw,
                               input logic mstart, input logic [3:0] alu, input logic mbusy);
    logic       ce, ePc, eReg, eMem, eStart, eStall, flagUpd;
    logic [3:0] nFlags;
    int         nPhase;
    reset        = rst;
    bus.Cond     = cond;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.NoWrite  = nowrite;
    bus.MemW     = memw;
    bus.FlagW    = flagw;
    bus.MStart   = mstart;
    bus.ALUFlags = alu;
    bus.MBusy    = mbusy;

    ce      = condPass(cond, mFlags);
    ePc     = pcs && ce;
    eReg    = regw && ce && !nowrite;
    eMem    = memw && ce;
    eStart  = 1'b0;
    eStall  = 1'b0;
    flagUpd = 1'b0;
    nPhase  = mPhase;
    if (rst) begin
      nPhase = 0;
    end else if (mPhase == 1) begin
      eStall = 1'b1;
      {ePc, eReg, eMem} = 3'b000;
      if (!mbusy) nPhase = 2;
    end else if (mPhase == 0 && mstart && ce) begin
      eStart = 1'b1;
      eStall = 1'b1;
      {ePc, eReg, eMem} = 3'b000;
      nPhase = 1;
    end else begin
      flagUpd = 1'b1;
      nPhase  = 0;
    end
    nFlags = mFlags;
    if (rst) nFlags = 4'b0000;
    else if (flagUpd && ce) begin
      if (flagw[1]) nFlags[3:2] = alu[3:2];
      if (flagw[0]) nFlags[1:0] = alu[1:0];
    end

    @(negedge clk);
    checkOutput(ePc, eReg, eMem, eStart, eStall);
    @(posedge clk);
    #1;
    mFlags = nFlags;
    mPhase = nPhase;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    {bus.PCS, bus.RegW, bus.NoWrite, bus.MemW, bus.MStart, bus.MBusy} = 6'b0;
    bus.FlagW    = 2'b00;
    bus.Cond     = 4'b1110;
    bus.ALUFlags = 4'b0000;
    @(posedge clk);
    #1;
    mFlags = 4'b0000;
    mPhase = 0;

    applyStimulus(1, 4'b1110, 1, 1, 0, 1, 2'b00, 1, 4'b0000, 0);
    checkValue("resetFlags", bus.Flags, 4'b0000);
    applyStimulus(0, 4'b0000, 0, 1, 0, 0, 2'b00, 0, 4'b0000, 0);
    applyStimulus(0, 4'b0001, 0, 1, 0, 0, 2'b00, 0, 4'b0000, 0);

    // Compare instruction: flags change, register write suppressed.
    applyStimulus(0, 4'b1110, 0, 1, 1, 0, 2'b11, 0, 4'b0100, 0);
    checkValue("cmpFlags", bus.Flags, 4'b0100);
    applyStimulus(0, 4'b0000, 1, 0, 0, 0, 2'b00, 0, 4'b0000, 0);

    applyStimulus(1, 4'b1110, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0);
    applyStimulus(0, 4'b1110, 0, 0, 0, 0, 2'b10, 0, 4'b1011, 0);
    checkValue("nzOnlyFlags", bus.Flags, 4'b1000);

    // Multi-cycle: start, three BUSY cycles, then DONE writes back.
    applyStimulus(0, 4'b1110, 0, 1, 0, 0, 2'b00, 1, 4'b0000, 1);
    applyStimulus(0, 4'b1110, 0, 1, 0, 0, 2'b00, 1, 4'b0000, 1);
    applyStimulus(0, 4'b1110, 0, 1, 0, 0, 2'b00, 1, 4'b0000, 1);
    applyStimulus(0, 4'b1110, 0, 1, 0, 0, 2'b00, 1, 4'b0000, 0);
    applyStimulus(0, 4'b1110, 0, 1, 0, 0, 2'b11, 1, 4'b0110, 0);
    checkValue("doneFlags", bus.Flags, 4'b0110);

    // Condition fails (Z=0 after this): MStart falls through as a no-op.
    applyStimulus(0, 4'b1110, 0, 0, 0, 0, 2'b11, 0, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 1, 1, 0, 1, 2'b00, 1, 4'b0000, 1);

    // Reset while BUSY.
    applyStimulus(0, 4'b1110, 0, 1, 0, 0, 2'b00, 1, 4'b0000, 1);
    applyStimulus(0, 4'b1110, 0, 1, 0, 0, 2'b00, 1, 4'b0000, 1);
    applyStimulus(1, 4'b1110, 0, 1, 0, 0, 2'b00, 1, 4'b0000, 1);
    checkValue("busyResetFlags", bus.Flags, 4'b0000);
    applyStimulus(0, 4'b0001, 0, 1, 0, 0, 2'b00, 0, 4'b0000, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
